user_in_debounce: RTL

Input conditioning stage for the user-input OR-reduce block. Takes 12 raw, asynchronous user inputs (switches, buttons, external flags), synchronises each to `clk`, debounces it with a per-channel stability counter, and presents a clean level vector that drives the downstream 12-bit `user_in` OR-reduce. Also emits per-channel rising-edge pulses and, optionally, write-1-to-clear sticky event flags for software or status logic.

---
 rtl/user_in_debounce.sv | 79 +++++++
 1 files changed

// File: rtl/user_in_debounce.sv
// user_in_debounce: sync + per-channel debounce for user inputs.
// Optional sticky flags built when USER_IN_DEBOUNCE_STICKY_EN is defined.
module user_in_debounce #(
  parameter int WIDTH           = 12,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] sticky_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CW-1:0]    cnt     [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] rise_nxt;

  // two-flop synchroniser per channel
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  end

  // stability count; accept once a new value held long enough
  always_comb begin
    acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != level_out[i]) begin
        if (cnt[i] == LAST) acc[i] = 1'b1;
        else cnt_nxt[i] = cnt[i] + 1'b1;
      end
    end
    rise_nxt = acc & s2;
  end

  // counters, debounced level and rise pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      level_out  <= '0;
      rise_pulse <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
      level_out  <= level_out ^ acc;
      rise_pulse <= rise_nxt;
    end
  end

`ifdef USER_IN_DEBOUNCE_STICKY_EN
  logic [WIDTH-1:0] sticky;

  // latched rise events, w1c; a new rise wins over clear
  always_ff @(posedge clk) begin
    if (reset) sticky <= '0;
    else sticky <= (sticky & ~clr) | rise_nxt;
  end

  assign sticky_out = sticky;
`else
  logic unused_clr;
  assign unused_clr = ^clr;
  assign sticky_out = '0;
`endif

endmodule
